// File: rtl/lcd_spi_cmd_seq_pkg.sv
// Shared types, register offsets and ROM images for the LCD command sequencer.
package lcd_spi_cmd_seq_pkg;

  typedef enum logic [1:0] {
    OpCmd   = 2'd0,
    OpData  = 2'd1,
    OpDelay = 2'd2,
    OpEnd   = 2'd3
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] arg;
  } cmd_entry_t;

  localparam logic [31:0] SPI_TX_OFFSET     = 32'h0;
  localparam logic [31:0] SPI_STATUS_OFFSET = 32'h4;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StPollReq,
    StPollWait,
    StWrReq,
    StWrWait,
    StDrain,
    StDelay,
    StDone
  } state_e;

  // What DRAIN hands over to once the line is quiet.
  typedef enum logic [1:0] {
    PendByte,
    PendDelay,
    PendDone
  } pend_e;

  // Image 0: column-address window set. Image 1: wake/display-on stream with
  // delays and no END, so it finishes by running off the last entry.
  function automatic cmd_entry_t default_rom(int unsigned image, int unsigned idx);
    cmd_entry_t e;
    e = '{op: OpEnd, arg: 8'h00};
    if (image == 0) begin
      case (idx)
        0:       e = '{op: OpCmd,  arg: 8'h2A};
        1:       e = '{op: OpData, arg: 8'h00};
        2:       e = '{op: OpData, arg: 8'h10};
        default: e = '{op: OpEnd,  arg: 8'h00};
      endcase
    end else begin
      case (idx)
        0:       e = '{op: OpCmd,   arg: 8'h11};
        1:       e = '{op: OpDelay, arg: 8'd3};
        2:       e = '{op: OpDelay, arg: 8'd0};
        3:       e = '{op: OpData,  arg: 8'h55};
        4:       e = '{op: OpCmd,   arg: 8'h29};
        default: e = '{op: OpData,  arg: 8'(idx)};
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/lcd_spi_cmd_rom.sv
// Constant command ROM with a registered read port (one cycle of latency).
module lcd_spi_cmd_rom
  import lcd_spi_cmd_seq_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 64,
  parameter int unsigned ROM_IMAGE = 0
) (
  input  logic                         clk_i,
  input  logic [$clog2(ROM_DEPTH)-1:0] addr_i,
  output logic [9:0]                   data_o
);

  logic [9:0] rom [ROM_DEPTH];
  logic [9:0] data_q;

  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
    assign rom[i] = default_rom(ROM_IMAGE, i);
  end

  always_ff @(posedge clk_i) begin
    data_q <= rom[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/lcd_spi_cmd_seq.sv
// Walks the command ROM and pushes each byte into the SPI TX register, keeping
// LCD DC stable while bytes are in flight and inserting panel delays.
module lcd_spi_cmd_seq
  import lcd_spi_cmd_seq_pkg::*;
#(
  parameter int unsigned ROM_DEPTH    = 64,
  parameter logic [31:0] SPI_BASE     = 32'h0,
  parameter int unsigned DELAY_UNIT   = 1000,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned ROM_IMAGE    = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        dev_req_o,
  output logic [31:0] dev_addr_o,
  output logic        dev_we_o,
  output logic [3:0]  dev_be_o,
  output logic [31:0] dev_wdata_o,
  input  logic        dev_rvalid_i,
  input  logic [31:0] dev_rdata_i,
  input  logic        spi_busy_i,
  output logic        lcd_dc_o,
  output logic        lcd_cs_o
);

  localparam int unsigned AW     = $clog2(ROM_DEPTH);
  localparam int unsigned DelayW = $clog2(255 * DELAY_UNIT + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  state_e            state_q, state_d;
  pend_e             pend_q, pend_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              dc_q, dc_d;
  logic              cs_q, cs_d;
  logic              pend_dc_q, pend_dc_d;
  logic [7:0]        arg_q, arg_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [DelayW-1:0] delay_q, delay_d;

  logic [9:0]        rom_rdata;
  cmd_entry_t        entry;
  logic              last;
  logic              advance;
  logic              entry_dc;
  logic [DelayW-1:0] delay_load;
  logic              unused_rdata;

  // Address with the next pointer so the entry is valid during FETCH.
  lcd_spi_cmd_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .ROM_IMAGE (ROM_IMAGE)
  ) u_rom (
    .clk_i  (clk_i),
    .addr_i (ptr_d),
    .data_o (rom_rdata)
  );

  assign entry        = cmd_entry_t'(rom_rdata);
  assign entry_dc     = (entry.op == OpData);
  assign last         = (ptr_q == AW'(ROM_DEPTH - 1));
  assign delay_load   = DelayW'(arg_q) * DelayW'(DELAY_UNIT);
  assign unused_rdata = ^dev_rdata_i[31:1];

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ptr_d     = ptr_q;
    dc_d      = dc_q;
    cs_d      = cs_q;
    pend_dc_d = pend_dc_q;
    arg_d     = arg_q;
    drain_d   = drain_q;
    delay_d   = delay_q;
    advance   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFetch;
          ptr_d   = '0;
          cs_d    = 1'b0;
        end
      end
      StFetch: begin
        arg_d   = entry.arg;
        drain_d = '0;
        unique case (entry.op)
          OpCmd, OpData: begin
            if (entry_dc == dc_q) begin
              state_d = StPollReq;
            end else begin
              pend_d    = PendByte;
              pend_dc_d = entry_dc;
              state_d   = StDrain;
            end
          end
          OpDelay: begin
            pend_d  = PendDelay;
            state_d = StDrain;
          end
          default: begin
            pend_d  = PendDone;
            state_d = StDrain;
          end
        endcase
      end
      StPollReq: state_d = StPollWait;
      StPollWait: begin
        if (dev_rvalid_i) begin
          state_d = dev_rdata_i[0] ? StPollReq : StWrReq;
        end
      end
      StWrReq:  state_d = StWrWait;
      StWrWait: advance = dev_rvalid_i;
      StDrain: begin
        if (spi_busy_i) begin
          drain_d = '0;
        end else if (drain_q == DrainW'(DRAIN_CYCLES - 1)) begin
          unique case (pend_q)
            PendByte: begin
              dc_d    = pend_dc_q;
              state_d = StPollReq;
            end
            PendDelay: begin
              if (arg_q == 8'd0) begin
                advance = 1'b1;
              end else begin
                delay_d = delay_load - DelayW'(1);
                state_d = StDelay;
              end
            end
            default: state_d = StDone;
          endcase
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StDelay: begin
        if (delay_q == '0) begin
          advance = 1'b1;
        end else begin
          delay_d = delay_q - DelayW'(1);
        end
      end
      StDone: begin
        cs_d    = 1'b1;
        dc_d    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Running off the last entry behaves as an implicit END; never wrap.
    if (advance) begin
      if (last) begin
        pend_d  = PendDone;
        drain_d = '0;
        state_d = StDrain;
      end else begin
        ptr_d   = ptr_q + AW'(1);
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pend_q    <= PendByte;
      ptr_q     <= '0;
      dc_q      <= 1'b1;
      cs_q      <= 1'b1;
      pend_dc_q <= 1'b0;
      arg_q     <= '0;
      drain_q   <= '0;
      delay_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      dc_q      <= dc_d;
      cs_q      <= cs_d;
      pend_dc_q <= pend_dc_d;
      arg_q     <= arg_d;
      drain_q   <= drain_d;
      delay_q   <= delay_d;
    end
  end

  assign busy_o      = (state_q != StIdle) && (state_q != StDone);
  assign done_o      = (state_q == StDone);
  assign dev_req_o   = (state_q == StPollReq) || (state_q == StWrReq);
  assign dev_we_o    = (state_q == StWrReq);
  assign dev_be_o    = 4'b0001;
  assign dev_addr_o  = (state_q == StPollReq) ? SPI_BASE + SPI_STATUS_OFFSET :
                       (state_q == StWrReq)   ? SPI_BASE + SPI_TX_OFFSET     : 32'h0;
  assign dev_wdata_o = (state_q == StWrReq) ? {24'h0, arg_q} : 32'h0;
  assign lcd_dc_o    = dc_q;
  assign lcd_cs_o    = cs_q;

endmodule

// File: tb/tb_lcd_spi_cmd_seq.sv
// Directed bench: two sequencer instances (END-terminated image, and a
// delay/no-END image) each with its own SPI bus model and monitor.
module tb_lcd_spi_cmd_seq;

  localparam logic [31:0] SpiBase = 32'h4000_0100;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy   [2];
  logic        done   [2];
  logic        dreq   [2];
  logic [31:0] daddr  [2];
  logic        dwe    [2];
  logic [3:0]  dbe    [2];
  logic [31:0] dwdata [2];
  logic        drvalid[2];
  logic [31:0] drdata [2];
  logic        spi_busy[2];
  logic        ddc    [2];
  logic        dcs    [2];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic clr;
  logic arm;
  int full_cfg[2];

  // Monitor state
  int rd_cnt[2], wr_n[2], done_cnt[2], req_total[2], bad_addr[2], full_viol[2];
  int reads_since[2];
  logic last_full[2];
  logic [7:0] wr_byte[2][16];
  logic wr_dc[2][16];
  logic wr_cs[2][16];
  int wr_rd[2][16];
  int wr_cyc[2][16];
  int hold, fall_cyc, dc1_cyc, nreq_cyc;
  logic post_2a;

  lcd_spi_cmd_seq #(
    .ROM_DEPTH (16), .SPI_BASE (SpiBase), .DELAY_UNIT (10), .DRAIN_CYCLES (4), .ROM_IMAGE (0)
  ) u_dut0 (
    .clk_i (clk), .rst_ni (rst_n), .start_i (start), .busy_o (busy[0]), .done_o (done[0]),
    .dev_req_o (dreq[0]), .dev_addr_o (daddr[0]), .dev_we_o (dwe[0]), .dev_be_o (dbe[0]),
    .dev_wdata_o (dwdata[0]), .dev_rvalid_i (drvalid[0]), .dev_rdata_i (drdata[0]),
    .spi_busy_i (spi_busy[0]), .lcd_dc_o (ddc[0]), .lcd_cs_o (dcs[0])
  );

  lcd_spi_cmd_seq #(
    .ROM_DEPTH (8), .SPI_BASE (SpiBase), .DELAY_UNIT (10), .DRAIN_CYCLES (4), .ROM_IMAGE (1)
  ) u_dut1 (
    .clk_i (clk), .rst_ni (rst_n), .start_i (start), .busy_o (busy[1]), .done_o (done[1]),
    .dev_req_o (dreq[1]), .dev_addr_o (daddr[1]), .dev_we_o (dwe[1]), .dev_be_o (dbe[1]),
    .dev_wdata_o (dwdata[1]), .dev_rvalid_i (drvalid[1]), .dev_rdata_i (drdata[1]),
    .spi_busy_i (spi_busy[1]), .lcd_dc_o (ddc[1]), .lcd_cs_o (dcs[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: response one cycle after req; status reports full for the
  // first full_cfg reads of a run.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      drvalid[i] <= dreq[i];
      drdata[i]  <= (dreq[i] && !dwe[i] && rd_cnt[i] <= full_cfg[i]) ? 32'h1 : 32'h0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        rd_cnt[i] = 0; wr_n[i] = 0; done_cnt[i] = 0; req_total[i] = 0;
        bad_addr[i] = 0; full_viol[i] = 0; reads_since[i] = 0; last_full[i] = 1'b0;
        spi_busy[i] = 1'b0;
        hold = 0; fall_cyc = -1; dc1_cyc = -1; nreq_cyc = -1; post_2a = 1'b0;
      end else begin
        if (drvalid[i]) last_full[i] = drdata[i][0];
        if (dreq[i]) begin
          req_total[i]++;
          if (dwe[i]) begin
            if (daddr[i] != SpiBase || dbe[i] != 4'b0001) bad_addr[i]++;
            if (last_full[i]) full_viol[i]++;
            if (wr_n[i] < 16) begin
              wr_byte[i][wr_n[i]] = dwdata[i][7:0];
              wr_dc[i][wr_n[i]]   = ddc[i];
              wr_cs[i][wr_n[i]]   = dcs[i];
              wr_rd[i][wr_n[i]]   = reads_since[i];
              wr_cyc[i][wr_n[i]]  = cyc;
            end
            wr_n[i]++;
            reads_since[i] = 0;
          end else begin
            if (daddr[i] != SpiBase + 32'h4) bad_addr[i]++;
            rd_cnt[i]++;
            reads_since[i]++;
          end
        end
        if (done[i]) done_cnt[i]++;
        if (i == 0) begin
          // Hold the shifter busy for 20 cycles starting with the 0x2A write.
          if (arm && dreq[0] && dwe[0] && dwdata[0][7:0] == 8'h2A) begin
            hold = 19; spi_busy[0] = 1'b1; post_2a = 1'b1;
          end else begin
            if (hold > 0) hold--;
            else if (spi_busy[0]) begin spi_busy[0] = 1'b0; fall_cyc = cyc; end
            if (post_2a && ddc[0] && dc1_cyc < 0) dc1_cyc = cyc;
            if (post_2a && dreq[0] && nreq_cyc < 0) nreq_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1) && n < 3000) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(done_cnt[0] >= 1 && done_cnt[1] >= 1), 32'd1);
    repeat (4) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  32'(busy[0]),  32'd0);
    check_eq({tag, "_done"},  32'(done[0]),  32'd0);
    check_eq({tag, "_req"},   32'(dreq[0]),  32'd0);
    check_eq({tag, "_we"},    32'(dwe[0]),   32'd0);
    check_eq({tag, "_addr"},  daddr[0],      32'd0);
    check_eq({tag, "_wdata"}, dwdata[0],     32'd0);
    check_eq({tag, "_dc"},    32'(ddc[0]),   32'd1);
    check_eq({tag, "_cs"},    32'(dcs[0]),   32'd1);
  endtask

  initial begin
    int base;
    logic found;
    logic [7:0] exp1 [6];
    exp1 = '{8'h11, 8'h55, 8'h29, 8'h05, 8'h06, 8'h07};
    rst_n = 1'b0; start = 1'b0; clr = 1'b1; arm = 1'b0;
    full_cfg[0] = 0; full_cfg[1] = 0;
    repeat (3) tick();
    check_reset_outputs("rst");
    clr = 1'b0;
    rst_n = 1'b1;
    tick();

    // Run A: window-set stream, busy held after 0x2A, stray start mid-run.
    arm = 1'b1;
    clear_mon();
    pulse_start();
    repeat (10) tick();
    check_eq("a_busy_mid", 32'(busy[0]), 32'd1);
    pulse_start();
    wait_done("a_done_seen");
    check_eq("a_wr_n", wr_n[0], 32'd3);
    check_eq("a_b0", 32'(wr_byte[0][0]), 32'h2A);
    check_eq("a_b1", 32'(wr_byte[0][1]), 32'h00);
    check_eq("a_b2", 32'(wr_byte[0][2]), 32'h10);
    check_eq("a_dc0", 32'(wr_dc[0][0]), 32'd0);
    check_eq("a_dc1", 32'(wr_dc[0][1]), 32'd1);
    check_eq("a_dc2", 32'(wr_dc[0][2]), 32'd1);
    for (int k = 0; k < 3; k++) check_eq($sformatf("a_rd%0d", k), wr_rd[0][k], 32'd1);
    check_eq("a_cs_active", 32'(wr_cs[0][0]), 32'd0);
    check_eq("a_done_cnt", done_cnt[0], 32'd1);
    check_eq("a_cs_end", 32'(dcs[0]), 32'd1);
    check_eq("a_busy_end", 32'(busy[0]), 32'd0);
    check_eq("a_dc_after_drain", dc1_cyc - fall_cyc, 32'd4);
    check_eq("a_req_after_drain", nreq_cyc - fall_cyc, 32'd4);
    check_eq("a_byte_cost", wr_cyc[0][2] - wr_cyc[0][1], 32'd5);
    check_eq("a_bad_addr", bad_addr[0], 32'd0);
    check_eq("b1_wr_n", wr_n[1], 32'd6);
    for (int k = 0; k < 6; k++) check_eq($sformatf("b1_b%0d", k), 32'(wr_byte[1][k]), 32'(exp1[k]));
    check_eq("b1_dc_cmd29", 32'(wr_dc[1][2]), 32'd0);
    check_eq("b1_rd_cnt", rd_cnt[1], 32'd6);
    check_eq("b1_delay_gap", wr_cyc[1][1] - wr_cyc[1][0], 32'd49);
    check_eq("b1_done_cnt", done_cnt[1], 32'd1);
    check_eq("b1_bad_addr", bad_addr[1], 32'd0);

    // Run B: TX FIFO reports full three times.
    arm = 1'b0;
    full_cfg[0] = 3;
    clear_mon();
    pulse_start();
    wait_done("f_done_seen");
    check_eq("f_wr_n", wr_n[0], 32'd3);
    check_eq("f_reads_first", wr_rd[0][0], 32'd4);
    check_eq("f_rd_cnt", rd_cnt[0], 32'd6);
    check_eq("f_full_viol", full_viol[0], 32'd0);
    check_eq("f_b0", 32'(wr_byte[0][0]), 32'h2A);

    // Run C: reset during WR_WAIT, then replay.
    full_cfg[0] = 0;
    clear_mon();
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (dreq[0] && dwe[0]) found = 1'b1;
    end
    check_eq("r_wr_seen", 32'(found), 32'd1);
    tick();
    check_eq("r_wrwait_noreq", 32'(dreq[0]), 32'd0);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("r_mid");
    base = req_total[0];
    repeat (5) tick();
    check_eq("r_no_req", req_total[0] - base, 32'd0);
    rst_n = 1'b1;
    clear_mon();
    pulse_start();
    wait_done("r_done_seen");
    check_eq("r_wr_n", wr_n[0], 32'd3);
    check_eq("r_b0", 32'(wr_byte[0][0]), 32'h2A);
    check_eq("r_b2", 32'(wr_byte[0][2]), 32'h10);
    check_eq("r_done_cnt", done_cnt[0], 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
